// File: rtl/debounce_pkg.sv
// Shared types and defaults for the D flip-flop input debouncer.
//   deb_state_e : 2-bit FSM encoding (IDLE_LOW=0, PEND_HIGH=1, IDLE_HIGH=2, PEND_LOW=3)
//   deb_out_t   : registered output bundle {d_out, rise, fall, stable}
//   *_DEF       : default parameter values for the top
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        PEND_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        PEND_LOW  = 2'd3
    } deb_state_e;

    typedef struct packed {
        logic d_out;
        logic rise;
        logic fall;
        logic stable;
    } deb_out_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk    : sampling clock
//   rst_n  : asynchronous active-low reset, clears every stage
//   d      : asynchronous input
//   d_sync : last stage of the chain (STAGES flops after d)
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic d_sync
);

    logic [STAGES-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= {q[STAGES-2:0], d};
    end

    assign d_sync = q[STAGES-1];

endmodule

// File: rtl/d_input_debouncer.sv
// Debounce front end for the lab D flip-flop: synchronizes din_raw, then a
// counter FSM requires DEBOUNCE_CYCLES consecutive synchronized samples of the
// new level before d_out moves. All outputs are registered.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   din_raw    : raw bouncy input
//   enable     : 1 = filter runs, 0 = state/counter/d_out frozen, strobes low
//   d_out      : debounced level
//   rise_pulse : one-cycle strobe with d_out 0->1
//   fall_pulse : one-cycle strobe with d_out 1->0
//   stable     : 1 while the FSM sits in an IDLE state
module d_input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din_raw,
    input  logic enable,
    output logic d_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam deb_out_t         OUT_RST  = '{d_out: 1'b0, rise: 1'b0, fall: 1'b0, stable: 1'b1};

    logic             s;
    deb_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    deb_out_t         out_q, out_nxt;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .d      (din_raw),
        .d_sync (s)
    );

    // State register: FSM, counter and the registered output bundle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            out_q <= OUT_RST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out_q <= out_nxt;
        end
    end

    // Next-state logic. In the PEND states the "level went back" test comes
    // first so a bounce on the commit edge is rejected rather than committed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (enable) begin
            case (state)
                IDLE_LOW: begin
                    if (s) begin state_nxt = PEND_HIGH; cnt_nxt = CNT_ONE; end
                    else   cnt_nxt = '0;
                end
                PEND_HIGH: begin
                    if (!s)                   begin state_nxt = IDLE_LOW;  cnt_nxt = '0; end
                    else if (cnt == CNT_LAST) begin state_nxt = IDLE_HIGH; cnt_nxt = '0; end
                    else                      cnt_nxt = cnt + CNT_ONE;
                end
                IDLE_HIGH: begin
                    if (!s) begin state_nxt = PEND_LOW; cnt_nxt = CNT_ONE; end
                    else    cnt_nxt = '0;
                end
                PEND_LOW: begin
                    if (s)                    begin state_nxt = IDLE_HIGH; cnt_nxt = '0; end
                    else if (cnt == CNT_LAST) begin state_nxt = IDLE_LOW;  cnt_nxt = '0; end
                    else                      cnt_nxt = cnt + CNT_ONE;
                end
                default: begin state_nxt = IDLE_LOW; cnt_nxt = '0; end
            endcase
        end
    end

    // Output logic: strobes only on a PEND->opposite-IDLE commit, so glitch
    // rejects (PEND->same-side IDLE) and frozen cycles leave them low.
    always_comb begin
        out_nxt        = out_q;
        out_nxt.rise   = 1'b0;
        out_nxt.fall   = 1'b0;
        out_nxt.stable = (state_nxt == IDLE_LOW) || (state_nxt == IDLE_HIGH);
        if (state == PEND_HIGH && state_nxt == IDLE_HIGH) begin
            out_nxt.d_out = 1'b1;
            out_nxt.rise  = 1'b1;
        end
        if (state == PEND_LOW && state_nxt == IDLE_LOW) begin
            out_nxt.d_out = 1'b0;
            out_nxt.fall  = 1'b1;
        end
    end

    assign d_out      = out_q.d_out;
    assign rise_pulse = out_q.rise;
    assign fall_pulse = out_q.fall;
    assign stable     = out_q.stable;

endmodule
